// File: rtl/store_write_buffer.sv
// Store write buffer: formats committed stores into lane-aligned write data
// and byte enables, queues them in a small FIFO, drains the FIFO to the
// data-bus write port and offers a word-address conflict check to loads.
//
// Handshakes (both ports): a transfer happens on a rising edge where
// valid && ready are both high. The push side (st_valid/st_ready) has
// st_ready independent of st_valid. On the bus side, bus_valid depends only
// on buffered state, and the bus_* payload holds stable from the cycle
// bus_valid rises until the cycle bus_ready accepts it.
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [2:0]                 st_type,
  input  logic [ADDR_W-1:0]          st_paddr,
  input  logic [31:0]                st_rtdata,
  input  logic                       st_uncached,
  output logic                       bus_valid,
  input  logic                       bus_ready,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [31:0]                bus_wrdata,
  output logic [3:0]                 bus_byteenable,
  output logic                       bus_uncached,
  input  logic [ADDR_W-1:0]          chk_paddr,
  output logic                       chk_hit,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  localparam logic [2:0] T_SB  = 3'd0;
  localparam logic [2:0] T_SH  = 3'd1;
  localparam logic [2:0] T_SW  = 3'd2;
  localparam logic [2:0] T_SWL = 3'd3;
  localparam logic [2:0] T_SWR = 3'd4;

  logic [WA_W-1:0]  ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [3:0]       ent_be   [DEPTH];
  logic [DEPTH-1:0] ent_unc;
  logic [DEPTH-1:0] ent_valid;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic [1:0]  off;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_data;
  logic        fmt_legal;
  logic        push;
  logic        pop;

  // Byte offset within the word drives every lane shift; the low bits of the
  // checked load address do not take part in the word compare.
  logic unused_chk_low;
  assign unused_chk_low = ^chk_paddr[1:0];
  assign off = st_paddr[1:0];

  // Build lane-aligned write data and byte enables from the raw rt value.
  always_comb begin
    fmt_be    = 4'b0000;
    fmt_data  = 32'h0;
    fmt_legal = 1'b1;
    case (st_type)
      T_SB: begin
        fmt_be   = 4'b0001 << off;
        fmt_data = st_rtdata << {off, 3'b000};
      end
      T_SH: begin
        fmt_be   = 4'b0011 << {off[1], 1'b0};
        fmt_data = st_rtdata << {off[1], 4'b0000};
      end
      T_SW: begin
        fmt_be   = 4'b1111;
        fmt_data = st_rtdata;
      end
      T_SWL: begin
        case (off)
          2'd0:    fmt_be = 4'b0001;
          2'd1:    fmt_be = 4'b0011;
          2'd2:    fmt_be = 4'b0111;
          default: fmt_be = 4'b1111;
        endcase
        // 3-off equals ~off for a two-bit offset.
        fmt_data = st_rtdata >> {~off, 3'b000};
      end
      T_SWR: begin
        fmt_be   = 4'b1111 << off;
        fmt_data = st_rtdata << {off, 3'b000};
      end
      default: fmt_legal = 1'b0;
    endcase
  end

  // Illegal store types are still accepted on the handshake but never queued.
  assign st_ready  = (count != CNT_W'(DEPTH));
  assign bus_valid = (count != '0);
  assign empty     = (count == '0);
  assign push      = st_valid && st_ready && fmt_legal;
  assign pop       = bus_valid && bus_ready;

  assign bus_addr       = {ent_addr[head], 2'b00};
  assign bus_wrdata     = ent_data[head];
  assign bus_byteenable = ent_be[head];
  assign bus_uncached   = ent_unc[head];

  // FIFO storage, pointers and occupancy; reset drops every pending entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_be[i]   <= '0;
      end
      ent_unc   <= '0;
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      // Head and tail never coincide while both push and pop fire, since
      // pop needs a non-empty and push a non-full buffer.
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      if (push) begin
        ent_addr[tail]  <= st_paddr[ADDR_W-1:2];
        ent_data[tail]  <= fmt_data;
        ent_be[tail]    <= fmt_be;
        ent_unc[tail]   <= st_uncached;
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Load conflict check over held entries only; an entry leaving this cycle
  // still counts, one arriving this cycle does not yet.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == chk_paddr[ADDR_W-1:2])) begin
        chk_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed stores with a queue-based model of
// the buffer checked on every falling edge, plus literal expectations.
module tb_store_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_type;
  logic [31:0] st_paddr;
  logic [31:0] st_rtdata;
  logic        st_uncached;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic [31:0] bus_wrdata;
  logic [3:0]  bus_byteenable;
  logic        bus_uncached;
  logic [31:0] chk_paddr;
  logic        chk_hit;
  logic        empty;
  logic [2:0]  count;

  int n_checks;
  int n_pass;

  // Model entry: {addr[31:0], wrdata[31:0], be[3:0], uncached}
  logic [68:0] exp_q[$];

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
    .st_paddr(st_paddr), .st_rtdata(st_rtdata), .st_uncached(st_uncached),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_wrdata(bus_wrdata), .bus_byteenable(bus_byteenable),
    .bus_uncached(bus_uncached), .chk_paddr(chk_paddr), .chk_hit(chk_hit),
    .empty(empty), .count(count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Store semantics in lane terms: lane k receives rt byte (k - sh) when that
  // byte exists, and the enabled lanes are the contiguous range lo..hi.
  // Returns {legal, wrdata[31:0], be[3:0]}.
  function automatic logic [36:0] fmt(input logic [2:0] t, input logic [1:0] off,
                                      input logic [31:0] rt);
    int o, sh, lo, hi, src;
    logic [31:0] d;
    logic [3:0]  b;
    logic        legal;
    o = int'(off);
    legal = 1'b1;
    sh = 0; lo = 0; hi = -1;
    case (t)
      3'd0: begin sh = o;          lo = o;  hi = o;      end
      3'd1: begin sh = 2 * (o / 2); lo = sh; hi = sh + 1; end
      3'd2: begin sh = 0;          lo = 0;  hi = 3;      end
      3'd3: begin sh = o - 3;      lo = 0;  hi = o;      end
      3'd4: begin sh = o;          lo = o;  hi = 3;      end
      default: legal = 1'b0;
    endcase
    d = 32'h0;
    b = 4'h0;
    for (int k = 0; k < 4; k++) begin
      src = k - sh;
      if (legal && src >= 0 && src <= 3) d[8*k +: 8] = rt[8*src +: 8];
      b[k] = legal && (k >= lo) && (k <= hi);
    end
    return {legal, d, b};
  endfunction

  // Scoreboard: compare DUT outputs with the model, then advance the model by
  // the transfers the coming rising edge will perform.
  logic [36:0] m_fmt;
  logic        m_hit;
  logic        m_push;
  logic        m_pop;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      check("rst_bus_valid", bus_valid, 0);
      check("rst_st_ready", st_ready, 1);
      check("rst_empty", empty, 1);
      check("rst_count", count, 0);
      check("rst_chk_hit", chk_hit, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_wrdata", bus_wrdata, 0);
      check("rst_bus_be", bus_byteenable, 0);
    end else begin
      m_hit = 1'b0;
      foreach (exp_q[i]) if (exp_q[i][68:39] == chk_paddr[31:2]) m_hit = 1'b1;
      check("st_ready", st_ready, exp_q.size() != DEPTH);
      check("count", count, exp_q.size());
      check("empty", empty, exp_q.size() == 0);
      check("bus_valid", bus_valid, exp_q.size() != 0);
      check("chk_hit", chk_hit, m_hit);
      if (exp_q.size() != 0) begin
        check("bus_addr", bus_addr, exp_q[0][68:37]);
        check("bus_wrdata", bus_wrdata, exp_q[0][36:5]);
        check("bus_be", bus_byteenable, exp_q[0][4:1]);
        check("bus_uncached", bus_uncached, exp_q[0][0]);
      end
      m_fmt  = fmt(st_type, st_paddr[1:0], st_rtdata);
      m_pop  = (exp_q.size() != 0) && bus_ready;
      m_push = st_valid && (exp_q.size() < DEPTH) && m_fmt[36];
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({st_paddr[31:2], 2'b00, m_fmt[35:4], m_fmt[3:0], st_uncached});
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input logic v, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d, input logic unc);
    st_valid    = v;
    st_type     = t;
    st_paddr    = a;
    st_rtdata   = d;
    st_uncached = unc;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus_ready = 1'b0;
    chk_paddr = 32'h0;
    set_st(0, 3'd0, 32'h0, 32'h0, 0);

    // Model pins
    check("fmt_swl3", fmt(3'd3, 2'd3, 32'h11223344), {1'b1, 32'h11223344, 4'hF});
    check("fmt_swl0", fmt(3'd3, 2'd0, 32'h11223344), {1'b1, 32'h00000011, 4'h1});
    check("fmt_sh3", fmt(3'd1, 2'd3, 32'h0000BEEF), {1'b1, 32'hBEEF0000, 4'hC});
    check("fmt_sb1", fmt(3'd0, 2'd1, 32'hAABBCCDD), {1'b1, 32'hBBCCDD00, 4'h2});
    check("fmt_swr3", fmt(3'd4, 2'd3, 32'h11223344), {1'b1, 32'h44000000, 4'h8});

    repeat (3) tick();
    check("reset_st_ready", st_ready, 1);
    check("reset_empty", empty, 1);
    rst_n = 1'b1;
    tick();

    // SW, held on the bus, then accepted
    set_st(1, 3'd2, 32'h1000_0004, 32'hAABBCCDD, 0);
    tick();
    set_st(0, 3'd0, 32'h0, 32'h0, 0);
    check("sw_valid", bus_valid, 1);
    check("sw_addr", bus_addr, 32'h1000_0004);
    check("sw_data", bus_wrdata, 32'hAABBCCDD);
    check("sw_be", bus_byteenable, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sw_hold_data", bus_wrdata, 32'hAABBCCDD);
      check("sw_hold_addr", bus_addr, 32'h1000_0004);
    end
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    check("sw_drained", empty, 1);

    // Sub-word stores, each popped while the next one is pushed
    set_st(1, 3'd0, 32'h1000_0003, 32'h0000_0012, 0);
    tick();
    check("sb_be", bus_byteenable, 4'b1000);
    check("sb_data", bus_wrdata, 32'h1200_0000);
    bus_ready = 1'b1;
    set_st(1, 3'd1, 32'h1000_0002, 32'h0000_BEEF, 1);
    tick();
    check("sh_be", bus_byteenable, 4'b1100);
    check("sh_data", bus_wrdata, 32'hBEEF_0000);
    check("sh_unc", bus_uncached, 1);
    set_st(1, 3'd3, 32'h1000_0001, 32'h1122_3344, 0);
    tick();
    check("swl_be", bus_byteenable, 4'b0011);
    check("swl_data", bus_wrdata, 32'h0000_1122);
    set_st(1, 3'd4, 32'h1000_0001, 32'h1122_3344, 0);
    tick();
    check("swr_be", bus_byteenable, 4'b1110);
    check("swr_data", bus_wrdata, 32'h2233_4400);
    set_st(0, 3'd0, 32'h0, 32'h0, 0);
    tick();
    check("sub_drained", empty, 1);

    // Fill, stalled push while full, then interleaved traffic across the wrap
    bus_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_st(1, 3'd2, 32'h3000_0000 + 32'(4 * i), 32'hF000_0000 + 32'(i), 0);
      tick();
    end
    check("full_st_ready", st_ready, 0);
    check("full_count", count, 4);
    set_st(1, 3'd2, 32'h3FFF_0000, 32'hDEAD_BEEF, 0);
    bus_ready = 1'b1;
    tick();
    check("full_pop_count", count, 3);
    check("full_pop_head", bus_wrdata, 32'hF000_0001);
    for (int i = 0; i < 8; i++) begin
      set_st(1, 3'd2, 32'h3100_0000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 0);
      tick();
    end
    set_st(0, 3'd0, 32'h0, 32'h0, 0);
    check("wrap_count", count, 3);
    check("wrap_head", bus_wrdata, 32'hC000_0005);
    repeat (3) tick();
    check("wrap_drained", empty, 1);

    // Load conflict check and reset in the middle of a drain
    bus_ready = 1'b0;
    chk_paddr = 32'h2000_0008;
    set_st(1, 3'd2, 32'h2000_0008, 32'h0000_0055, 0);
    tick();
    set_st(0, 3'd0, 32'h0, 32'h0, 0);
    chk_paddr = 32'h2000_000B;
    #1;
    check("chk_same_word", chk_hit, 1);
    chk_paddr = 32'h2000_000C;
    #1;
    check("chk_next_word", chk_hit, 0);
    chk_paddr = 32'h2000_0008;
    set_st(1, 3'd2, 32'h2000_0010, 32'h0000_0066, 0);
    bus_ready = 1'b1;
    tick();
    set_st(0, 3'd0, 32'h0, 32'h0, 0);
    chk_paddr = 32'h2000_0010;
    #1;
    check("chk_pending", chk_hit, 1);
    check("pre_rst_valid", bus_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus_valid, 0);
    check("mid_rst_chk", chk_hit, 0);
    check("mid_rst_count", count, 0);
    bus_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Illegal store types are handshaken and dropped
    for (int t = 5; t < 8; t++) begin
      set_st(1, 3'(t), 32'h4000_0000, 32'h0000_0001, 0);
      #1;
      check("illegal_ready", st_ready, 1);
      tick();
      check("illegal_count", count, 0);
      check("illegal_valid", bus_valid, 0);
    end
    set_st(0, 3'd0, 32'h0, 32'h0, 0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
